// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared state encoding and sizing helpers for the sequential multiplier
package seq_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 64;

  // Counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// rtl/seq_mult_ctrl_if.sv - operand/result handshake bundle between the pipeline and the multiplier
interface seq_mult_ctrl_if
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_ready;

  modport master (
    output start_valid, A, B, result_ready,
    input  start_ready, busy, result, result_valid
  );

  modport slave (
    input  start_valid, A, B, result_ready,
    output start_ready, busy, result, result_valid
  );

endinterface

// File: rtl/mult_pp_step.sv
// rtl/mult_pp_step.sv - one shift-and-add step: acc plus the multiplicand gated by the multiplier bit
module mult_pp_step
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mcand,
  input  logic             mplier_bit,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] pp;

  assign pp       = mcand & {WIDTH{mplier_bit}};
  assign acc_next = acc + pp;

endmodule

// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - shift-and-add multiplier controller, low WIDTH bits of A*B
// Optional SEQ_MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic            clk,
  input logic            reset,
  seq_mult_ctrl_if.slave bus
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] count;

  logic load;
  logic step;
  logic finish;
  logic last_step;
  logic start_ready_c;
  logic busy_c;
  logic result_valid_c;

  mult_pp_step #(
    .WIDTH(WIDTH)
  ) u_pp_step (
    .acc       (acc),
    .mcand     (mcand),
    .mplier_bit(mplier[0]),
    .acc_next  (acc_next)
  );

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Once the bits still to be consumed are all zero, further steps add nothing.
  assign last_step = (count == LAST_CNT) || ((mplier >> 1) == '0);
`else
  assign last_step = (count == LAST_CNT);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    start_ready_c  = 1'b0;
    busy_c         = 1'b0;
    result_valid_c = 1'b0;
    load           = 1'b0;
    step           = 1'b0;
    finish         = 1'b0;
    case (state)
      S_IDLE: begin
        start_ready_c = 1'b1;
        if (bus.start_valid) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy_c = 1'b1;
        step   = 1'b1;
        if (last_step) begin
          finish     = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        // start_ready stays low here, so a consume and a new accept never share an edge.
        busy_c         = 1'b1;
        result_valid_c = 1'b1;
        if (bus.result_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      result_q <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= bus.A;
      mplier <= bus.B;
      count  <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CNT_W'(1);
      if (finish) begin
        result_q <= acc_next;
      end
    end
  end

  assign bus.start_ready  = start_ready_c;
  assign bus.busy         = busy_c;
  assign bus.result_valid = result_valid_c;
  assign bus.result       = result_q;

endmodule
